stream_adder_pipe: RTL and testbench

//  Parametrised, fully registered successor of the combinational stream incrementer.

---
 rtl/stream_adder_pipe.sv | 166 ++++++++++++++++
 tb/tb_stream_adder_pipe.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_adder_pipe.sv
// ---------------------------------------------------------------------------
// stream_adder_pipe
//
// Adds a per-packet increment to every data beat of a valid/ready/last
// stream. The increment is sampled on the first beat of each packet and is
// reused for the rest of that packet. The sum can either wrap or saturate.
//
// Both stream sides are registered:
//   - The output register (OR) drives source_valid, source_last,
//     source_data and overflow.
//   - A one-entry skid buffer (SK) catches the beat that is in flight when
//     the sink stalls. This keeps one beat per cycle while sink_ready is
//     driven from a register.
//
// Ports
//   sys_clk       in   clock, all logic on the rising edge
//   sys_rst_n     in   asynchronous active-low reset
//   sink_valid    in   input beat valid
//   sink_last     in   input beat is the last beat of its packet
//   sink_data     in   input beat data            [DATA_WIDTH]
//   sink_ready    out  registered ready to upstream
//   increment     in   per-packet addend, sampled on the first beat [DATA_WIDTH]
//   source_valid  out  output beat valid
//   source_last   out  output beat is the last beat of its packet
//   source_data   out  sink_data + increment      [DATA_WIDTH]
//   source_ready  in   downstream ready
//   overflow      out  the addition for this output beat overflowed
//   pkt_count     out  packets delivered downstream, wraps [CNT_WIDTH]
// ---------------------------------------------------------------------------
module stream_adder_pipe #(
  parameter int DATA_WIDTH = 8,
  parameter bit SATURATE   = 1'b0,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  sink_valid,
  input  logic                  sink_last,
  input  logic [DATA_WIDTH-1:0] sink_data,
  output logic                  sink_ready,
  input  logic [DATA_WIDTH-1:0] increment,
  output logic                  source_valid,
  output logic                  source_last,
  output logic [DATA_WIDTH-1:0] source_data,
  input  logic                  source_ready,
  output logic                  overflow,
  output logic [CNT_WIDTH-1:0]  pkt_count
);

  typedef enum logic {SOP, MID} state_t;

  // A computed beat. The result, last flag and overflow flag travel
  // together through OR and SK.
  typedef struct packed {
    logic                  last;
    logic                  ovf;
    logic [DATA_WIDTH-1:0] data;
  } beat_t;

  state_t                state_reg, state_next;
  logic [DATA_WIDTH-1:0] inc_q_reg, inc_q_next;
  beat_t                 or_reg, or_next;
  logic                  or_valid_reg, or_valid_next;
  beat_t                 sk_reg, sk_next;
  logic                  sk_valid_reg, sk_valid_next;
  logic                  sink_ready_reg, sink_ready_next;
  logic [CNT_WIDTH-1:0]  pkt_count_reg, pkt_count_next;

  logic                  accept;
  logic                  consume;
  logic [DATA_WIDTH-1:0] inc_sel;
  logic [DATA_WIDTH:0]   sum;
  beat_t                 beat;

  assign accept  = sink_valid & sink_ready_reg;
  assign consume = or_valid_reg & source_ready;

  // The first beat of a packet uses the live increment input.
  // Later beats use the value latched on that first beat.
  assign inc_sel = (state_reg == SOP) ? increment : inc_q_reg;
  assign sum     = {1'b0, sink_data} + {1'b0, inc_sel};

  always_comb begin
    beat.last = sink_last;
    beat.ovf  = sum[DATA_WIDTH];
    if (SATURATE && sum[DATA_WIDTH]) begin
      beat.data = '1;
    end else begin
      beat.data = sum[DATA_WIDTH-1:0];
    end
  end

  always_comb begin
    state_next     = state_reg;
    inc_q_next     = inc_q_reg;
    or_next        = or_reg;
    or_valid_next  = or_valid_reg;
    sk_next        = sk_reg;
    sk_valid_next  = sk_valid_reg;
    pkt_count_next = pkt_count_reg;

    if (accept) begin
      if (state_reg == SOP) begin
        inc_q_next = increment;
      end
      state_next = sink_last ? SOP : MID;
    end

    if (consume) begin
      if (sk_valid_reg) begin
        // SK refills OR. A new beat cannot arrive in this cycle,
        // because sink_ready is low whenever SK is full.
        or_next       = sk_reg;
        sk_valid_next = 1'b0;
      end else if (accept) begin
        or_next = beat;
      end else begin
        or_valid_next = 1'b0;
      end
    end else if (accept) begin
      if (!or_valid_reg) begin
        or_next       = beat;
        or_valid_next = 1'b1;
      end else begin
        sk_next       = beat;
        sk_valid_next = 1'b1;
      end
    end

    if (consume && or_reg.last) begin
      pkt_count_next = pkt_count_reg + 1'b1;
    end

    sink_ready_next = ~sk_valid_next;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_reg      <= SOP;
      inc_q_reg      <= '0;
      or_reg         <= '0;
      or_valid_reg   <= 1'b0;
      sk_reg         <= '0;
      sk_valid_reg   <= 1'b0;
      sink_ready_reg <= 1'b0;
      pkt_count_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      inc_q_reg      <= inc_q_next;
      or_reg         <= or_next;
      or_valid_reg   <= or_valid_next;
      sk_reg         <= sk_next;
      sk_valid_reg   <= sk_valid_next;
      sink_ready_reg <= sink_ready_next;
      pkt_count_reg  <= pkt_count_next;
    end
  end

  assign sink_ready   = sink_ready_reg;
  assign source_valid = or_valid_reg;
  assign source_last  = or_reg.last;
  assign source_data  = or_reg.data;
  assign overflow     = or_reg.ovf;
  assign pkt_count    = pkt_count_reg;

endmodule

// File: tb/tb_stream_adder_pipe.sv
// ---------------------------------------------------------------------------
// Testbench for stream_adder_pipe.
//
// Two instances share the same stimulus:
//   - dut_a wraps on overflow and has a 4-bit packet counter.
//   - dut_b saturates on overflow and has a 16-bit packet counter.
//
// A queue-based reference model follows every handshake. Each cycle the
// bench compares both instances against the model. The directed steps add
// checks against hand-computed constants.
// ---------------------------------------------------------------------------
module tb_stream_adder_pipe;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic       sink_valid;
  logic       sink_last;
  logic [7:0] sink_data;
  logic [7:0] increment;
  logic       source_ready;

  logic       a_sink_ready, a_source_valid, a_source_last, a_overflow;
  logic [7:0] a_source_data;
  logic [3:0] a_pkt_count;
  logic       b_sink_ready, b_source_valid, b_source_last, b_overflow;
  logic [7:0] b_source_data;
  logic [15:0] b_pkt_count;

  always #5 sys_clk = ~sys_clk;

  stream_adder_pipe #(.DATA_WIDTH(8), .SATURATE(1'b0), .CNT_WIDTH(4)) dut_a (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .sink_valid(sink_valid), .sink_last(sink_last), .sink_data(sink_data),
    .sink_ready(a_sink_ready), .increment(increment),
    .source_valid(a_source_valid), .source_last(a_source_last),
    .source_data(a_source_data), .source_ready(source_ready),
    .overflow(a_overflow), .pkt_count(a_pkt_count)
  );

  stream_adder_pipe #(.DATA_WIDTH(8), .SATURATE(1'b1), .CNT_WIDTH(16)) dut_b (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .sink_valid(sink_valid), .sink_last(sink_last), .sink_data(sink_data),
    .sink_ready(b_sink_ready), .increment(increment),
    .source_valid(b_source_valid), .source_last(b_source_last),
    .source_data(b_source_data), .source_ready(source_ready),
    .overflow(b_overflow), .pkt_count(b_pkt_count)
  );

  // Expected beat: wrapped result, saturated result, last flag, overflow flag.
  typedef struct packed {
    logic [7:0] d0;
    logic [7:0] d1;
    logic       last;
    logic       ovf;
  } beat_t;

  beat_t       q[$];
  logic        m_sop;
  logic [7:0]  m_inc;
  logic [31:0] m_pkts;
  bit          armed;
  int          checks;
  int          failures;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    bit exp_valid;
    exp_valid = (q.size() > 0);
    chk("a_source_valid", a_source_valid, exp_valid);
    chk("b_source_valid", b_source_valid, exp_valid);
    if (exp_valid) begin
      chk("a_source_data", a_source_data, q[0].d0);
      chk("b_source_data", b_source_data, q[0].d1);
      chk("a_source_last", a_source_last, q[0].last);
      chk("b_source_last", b_source_last, q[0].last);
      chk("a_overflow", a_overflow, q[0].ovf);
      chk("b_overflow", b_overflow, q[0].ovf);
    end
    chk("a_sink_ready", a_sink_ready, armed && (q.size() < 2));
    chk("b_sink_ready", b_sink_ready, armed && (q.size() < 2));
    chk("a_pkt_count", a_pkt_count, m_pkts[3:0]);
    chk("b_pkt_count", b_pkt_count, m_pkts[15:0]);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_a_valid"}, a_source_valid, 0);
    chk({tag, "_a_last"}, a_source_last, 0);
    chk({tag, "_a_data"}, a_source_data, 0);
    chk({tag, "_a_ovf"}, a_overflow, 0);
    chk({tag, "_a_cnt"}, a_pkt_count, 0);
    chk({tag, "_a_ready"}, a_sink_ready, 0);
    chk({tag, "_b_valid"}, b_source_valid, 0);
    chk({tag, "_b_data"}, b_source_data, 0);
    chk({tag, "_b_cnt"}, b_pkt_count, 0);
    chk({tag, "_b_ready"}, b_sink_ready, 0);
  endtask

  // Advance one clock. The handshakes are sampled before the edge, then the
  // model is updated and all outputs are checked 1 time unit after the edge.
  task automatic cycle();
    bit         acc, cons;
    beat_t      b;
    logic [7:0] inc;
    logic [8:0] s;
    acc  = sink_valid && a_sink_ready;
    cons = a_source_valid && source_ready;
    inc  = m_sop ? increment : m_inc;
    s    = {1'b0, sink_data} + {1'b0, inc};
    b.d0   = s[7:0];
    b.d1   = s[8] ? 8'hFF : s[7:0];
    b.ovf  = s[8];
    b.last = sink_last;
    @(posedge sys_clk);
    #1;
    if (sys_rst_n) armed = 1'b1;
    if (cons && q.size() > 0) begin
      if (q[0].last) m_pkts++;
      void'(q.pop_front());
    end
    if (acc) begin
      if (m_sop) m_inc = increment;
      m_sop = sink_last;
      q.push_back(b);
    end
    check_outputs();
  endtask

  task automatic apply_reset();
    sys_rst_n  = 1'b0;
    sink_valid = 1'b1;
    q.delete();
    m_sop  = 1'b1;
    m_inc  = 8'h00;
    m_pkts = 0;
    armed  = 1'b0;
    #1;
    check_zero("rst_async");
    repeat (2) begin
      @(posedge sys_clk);
      #1;
      check_zero("rst_hold");
    end
    sink_valid = 1'b0;
    #2 sys_rst_n = 1'b1;
    #1;
    chk("rst_ready_before_edge", a_sink_ready, 0);
    cycle();
    chk("rst_ready_after_edge", a_sink_ready, 1);
  endtask

  task automatic send(input logic [7:0] d, input logic l, input logic [7:0] inc,
                      output int n);
    bit done;
    done = 1'b0;
    n    = 0;
    sink_valid = 1'b1;
    sink_data  = d;
    sink_last  = l;
    increment  = inc;
    while (!done && n < 20) begin
      done = a_sink_ready;
      cycle();
      n++;
    end
    chk("send_accepted", done, 1);
    sink_valid = 1'b0;
  endtask

  initial begin
    int n;
    int idx;
    int sent;
    int cyc;
    checks       = 0;
    failures     = 0;
    sink_valid   = 1'b0;
    sink_last    = 1'b0;
    sink_data    = 8'h00;
    increment    = 8'h00;
    source_ready = 1'b1;
    sys_rst_n    = 1'b0;

    // 1: reset with sink_valid held high; sink_ready rises one edge after release.
    #2;
    apply_reset();

    // 2: streaming, +1, 4-beat packet, latency 1, one beat per cycle.
    for (int i = 0; i < 4; i++) begin
      send(8'h10 + 8'(i), (i == 3), 8'h01, n);
      chk("stream_rate", n, 1);
      chk("stream_data", a_source_data, 8'h11 + 8'(i));
      chk("stream_last", a_source_last, (i == 3));
    end
    cycle();
    chk("stream_pkt_count", a_pkt_count, 4'd1);

    // 3: the increment is latched on the first beat only.
    send(8'h20, 1'b0, 8'h05, n); chk("latch_b0", a_source_data, 8'h25);
    send(8'h21, 1'b0, 8'h09, n); chk("latch_b1", a_source_data, 8'h26);
    send(8'h22, 1'b1, 8'h09, n); chk("latch_b2", a_source_data, 8'h27);
    send(8'h30, 1'b1, 8'h09, n); chk("latch_next_pkt", a_source_data, 8'h39);

    // 4: overflow, wrapping vs saturating.
    send(8'hFE, 1'b1, 8'h03, n);
    chk("ovf_wrap_data", a_source_data, 8'h01);
    chk("ovf_sat_data", b_source_data, 8'hFF);
    chk("ovf_wrap_flag", a_overflow, 1);
    chk("ovf_sat_flag", b_overflow, 1);
    send(8'h10, 1'b1, 8'h03, n);
    chk("no_ovf_data", a_source_data, 8'h13);
    chk("no_ovf_flag", b_overflow, 0);
    cycle();

    // 5a: backpressure, source_ready low for 5 cycles while streaming.
    source_ready = 1'b0;
    increment    = 8'h02;
    idx          = 0;
    for (int c = 0; c < 30; c++) begin
      source_ready = (c >= 5);
      sink_valid   = (idx < 8);
      sink_data    = 8'h40 + 8'(idx);
      sink_last    = (idx == 7);
      if (sink_valid && a_sink_ready) idx++;
      cycle();
      if (c == 4) begin
        chk("bp_ready_low", a_sink_ready, 0);
        chk("bp_stable_data", a_source_data, 8'h42);
        chk("bp_stored", idx, 2);
      end
    end
    sink_valid = 1'b0;
    chk("bp_all_sent", idx, 8);
    chk("bp_drained", a_source_valid, 0);

    // 5b: random valid/ready over 1000 beats against the model.
    sent = 0;
    cyc  = 0;
    while (sent < 1000 && cyc < 20000) begin
      sink_valid   = ($urandom_range(0, 3) != 0);
      sink_data    = 8'($urandom);
      sink_last    = ($urandom_range(0, 3) == 0);
      increment    = 8'($urandom);
      source_ready = ($urandom_range(0, 3) != 0);
      if (sink_valid && a_sink_ready) sent++;
      cycle();
      cyc++;
    end
    chk("rand_beats_sent", sent, 1000);
    sink_valid   = 1'b0;
    source_ready = 1'b1;
    repeat (3) cycle();

    // 6a: the 4-bit packet counter wraps after 16 packets.
    apply_reset();
    for (int i = 0; i < 17; i++) send(8'(i), 1'b1, 8'h01, n);
    cycle();
    chk("wrap_cnt4", a_pkt_count, 4'd1);
    chk("wrap_cnt16", b_pkt_count, 16'd17);

    // 6b: reset mid-packet drops the beats in flight; the next packet
    // samples a fresh increment.
    source_ready = 1'b0;
    send(8'h60, 1'b0, 8'h04, n);
    send(8'h61, 1'b0, 8'h04, n);
    source_ready = 1'b1;
    apply_reset();
    send(8'h50, 1'b1, 8'h07, n);
    chk("fresh_inc_data", a_source_data, 8'h57);
    cycle();
    chk("fresh_pkt_count", a_pkt_count, 4'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
